// File: rtl/eth_pcs_params.sv
// Shared constants and helpers for the 64b/66b PCS TX path.
// Block geometry, gearbox period and bit-order utilities.
package eth_pcs_params;

  localparam int PCS_W_SYNC   = 2;
  localparam int PCS_W_BLK    = 64;
  localparam int TX_GB_PERIOD = 33;

  // Width of a slice-index counter; never narrower than 1 bit.
  function automatic int tcnt_w(input int tpb);
    return (tpb <= 1) ? 1 : $clog2(tpb);
  endfunction

  // Mirror the low w bits of d; upper bits come back zero.
  function automatic logic [63:0] reverse(
    input logic [63:0] d,
    input int          w
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = d[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_pcs_tx_gearbox_cnt.sv
// Gearbox period counter: upstream enable, slice index,
// block-start strobe and block index within the period.
module eth_pcs_tx_gearbox_cnt
  import eth_pcs_params::*;
#(
  parameter int TPB = 2,
  parameter int TW  = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  output logic          o_clk_en,
  output logic [TW-1:0] o_trans_cnt,
  output logic          o_blk_start,
  output logic [4:0]    o_blk_idx
);

  localparam int CW = $clog2(TX_GB_PERIOD);
  localparam int SH = $clog2(TPB);
  localparam logic [CW-1:0] LAST =
    CW'(TX_GB_PERIOD - 1);

  logic [CW-1:0] q_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q_cnt <= '0;
    end else if (q_cnt == LAST) begin
      q_cnt <= '0;
    end else begin
      q_cnt <= q_cnt + CW'(1);
    end
  end

  // TPB is a power of two, so the modulo is a bit slice.
  if (TPB == 1) begin : g_one
    assign o_trans_cnt = '0;
  end else begin : g_mod
    assign o_trans_cnt = q_cnt[TW-1:0];
  end

  assign o_clk_en    = (q_cnt != LAST);
  assign o_blk_start = o_clk_en &&
                       (o_trans_cnt == '0);
  assign o_blk_idx   = 5'(q_cnt >> SH);

endmodule

// File: rtl/eth_pcs_tx_gearbox_mw.sv
// 66b -> W_PMA TX gearbox with upstream throttling.
// In: i_clk, i_reset_n, i_valid, i_sync_data, i_scr_data.
// Out: o_clk_en, o_trans_cnt, o_blk_start, o_pma_data, o_err.
module eth_pcs_tx_gearbox_mw
  import eth_pcs_params::*;
#(
  parameter int W_PMA     = 32,
  parameter int W_SYNC    = 2,
  parameter int W_BLK     = 64,
  parameter bit MSB_FIRST = 1'b0,
  localparam int TW = tcnt_w(W_BLK / W_PMA)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [W_SYNC-1:0] i_sync_data,
  input  logic [W_PMA-1:0]  i_scr_data,
  output logic              o_clk_en,
  output logic [TW-1:0]     o_trans_cnt,
  output logic              o_blk_start,
  output logic [W_PMA-1:0]  o_pma_data,
  output logic              o_err
);

  localparam int TPB = W_BLK / W_PMA;
  localparam int BW  = 2 * W_PMA + W_SYNC;
  localparam int FW  = $clog2(W_PMA + 1);

  if (!(W_PMA == 16 || W_PMA == 32 ||
        W_PMA == 64)) begin : g_bad_w
    $error("W_PMA must be 16, 32 or 64");
  end
  if (W_SYNC != PCS_W_SYNC) begin : g_bad_s
    $error("W_SYNC must be 2");
  end
  if (W_BLK != PCS_W_BLK) begin : g_bad_b
    $error("W_BLK must be 64");
  end

  logic [4:0]    blk_idx;
  logic [BW-1:0] q_buf;
  logic [BW-1:0] d_buf;
  logic [BW-1:0] app;
  logic [FW-1:0] q_fill;
  logic [FW-1:0] d_fill;
  logic          bad;
  logic [63:0]   rev;

  eth_pcs_tx_gearbox_cnt #(
    .TPB (TPB),
    .TW  (TW)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .o_clk_en    (o_clk_en),
    .o_trans_cnt (o_trans_cnt),
    .o_blk_start (o_blk_start),
    .o_blk_idx   (blk_idx)
  );

  // q_fill counts bits held beyond the word now on the output.
  // A missing slice is replaced by zeros so alignment holds.
  always_comb begin
    app    = '0;
    d_fill = q_fill;
    bad    = o_clk_en && !i_valid;
    if (o_clk_en && i_valid) begin
      if (o_blk_start) begin
        app = BW'({i_scr_data, i_sync_data});
      end else begin
        app = BW'(i_scr_data);
      end
    end
    if (!o_clk_en) begin
      d_fill = '0;
    end else if (o_blk_start) begin
      d_fill = q_fill + FW'(W_SYNC);
    end
    d_buf = (q_buf >> W_PMA) | (app << q_fill);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q_buf  <= '0;
      q_fill <= '0;
      o_err  <= 1'b0;
    end else begin
      q_buf  <= d_buf;
      q_fill <= d_fill;
      if (bad) o_err <= 1'b1;
    end
  end

  always_comb begin
    rev = reverse(64'(q_buf[W_PMA-1:0]), W_PMA);
    if (MSB_FIRST) begin
      o_pma_data = rev[W_PMA-1:0];
    end else begin
      o_pma_data = q_buf[W_PMA-1:0];
    end
  end

  // The pause drains exactly one word of surplus.
  a_fill_pause: assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
    !o_clk_en |-> (q_fill == FW'(W_PMA)));

  a_fill_blk: assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
    o_blk_start |-> (q_fill == FW'({blk_idx, 1'b0})));

endmodule

// File: tb/tb_eth_pcs_tx_gearbox_mw.sv
// Bench for eth_pcs_tx_gearbox_mw: four widths/orders in parallel.
// Expected serial bits are queued at drive time and popped per word.
module tb_eth_pcs_tx_gearbox_mw;

  localparam int ND = 4;
  localparam int WP [ND] = '{32, 16, 64, 32};
  localparam bit MS [ND] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0] vld;
  logic [1:0]    syi [ND];
  logic [63:0]   scr [ND];
  logic [ND-1:0] ce, bs, er;
  logic [31:0]   pma_a, pma_d;
  logic [15:0]   pma_b;
  logic [63:0]   pma_c;
  logic [0:0]    tc_a, tc_c, tc_d;
  logic [1:0]    tc_b;
  logic [63:0]   pma [ND];
  logic [1:0]    tcv [ND];

  assign pma[0] = 64'(pma_a);
  assign pma[1] = 64'(pma_b);
  assign pma[2] = pma_c;
  assign pma[3] = 64'(pma_d);
  assign tcv[0] = 2'(tc_a);
  assign tcv[1] = tc_b;
  assign tcv[2] = 2'(tc_c);
  assign tcv[3] = 2'(tc_d);

  eth_pcs_tx_gearbox_mw #(
    .W_PMA(32), .W_SYNC(2), .W_BLK(64), .MSB_FIRST(1'b0)
  ) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[0]),
    .i_sync_data(syi[0]), .i_scr_data(scr[0][31:0]),
    .o_clk_en(ce[0]), .o_trans_cnt(tc_a),
    .o_blk_start(bs[0]), .o_pma_data(pma_a), .o_err(er[0])
  );

  eth_pcs_tx_gearbox_mw #(
    .W_PMA(16), .W_SYNC(2), .W_BLK(64), .MSB_FIRST(1'b0)
  ) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[1]),
    .i_sync_data(syi[1]), .i_scr_data(scr[1][15:0]),
    .o_clk_en(ce[1]), .o_trans_cnt(tc_b),
    .o_blk_start(bs[1]), .o_pma_data(pma_b), .o_err(er[1])
  );

  eth_pcs_tx_gearbox_mw #(
    .W_PMA(64), .W_SYNC(2), .W_BLK(64), .MSB_FIRST(1'b0)
  ) u_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[2]),
    .i_sync_data(syi[2]), .i_scr_data(scr[2]),
    .o_clk_en(ce[2]), .o_trans_cnt(tc_c),
    .o_blk_start(bs[2]), .o_pma_data(pma_c), .o_err(er[2])
  );

  eth_pcs_tx_gearbox_mw #(
    .W_PMA(32), .W_SYNC(2), .W_BLK(64), .MSB_FIRST(1'b1)
  ) u_d (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[3]),
    .i_sync_data(syi[3]), .i_scr_data(scr[3][31:0]),
    .o_clk_en(ce[3]), .o_trans_cnt(tc_d),
    .o_blk_start(bs[3]), .o_pma_data(pma_d), .o_err(er[3])
  );

  int          checks = 0;
  int          failures = 0;
  int          mode = 0;
  int          mcnt [ND];
  logic [63:0] blk [ND];
  logic [63:0] inc [ND];
  logic [1:0]  bsync [ND];
  bit          merr [ND];
  bit          sb [ND][$];

  task automatic new_block(input int d);
    case (mode)
      0: begin
        blk[d] = inc[d];
        inc[d] = inc[d] + 64'd1;
        bsync[d] = 2'b01;
      end
      1: begin
        blk[d] = {$urandom, $urandom};
        bsync[d] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      end
      default: begin
        blk[d] = '0;
        bsync[d] = 2'b01;
      end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mcnt[d] = 0;
      merr[d] = 1'b0;
      sb[d].delete();
    end
  endtask

  // One clock: check control outputs, drive a slice, check the word.
  task automatic cycle(input bit drop);
    for (int d = 0; d < ND; d++) begin
      int tpb;
      int tc;
      bit en;
      logic [63:0] mask;
      logic [63:0] sl;
      tpb = 64 / WP[d];
      en = (mcnt[d] != 32);
      tc = mcnt[d] % tpb;
      checks += 4;
      if (ce[d] !== en) begin
        failures++;
        $display("FAIL clk_en dut%0d cnt=%0d got=%b want=%b",
                 d, mcnt[d], ce[d], en);
      end
      if (tcv[d] !== 2'(tc)) begin
        failures++;
        $display("FAIL trans_cnt dut%0d cnt=%0d got=%0d want=%0d",
                 d, mcnt[d], tcv[d], tc);
      end
      if (bs[d] !== (en && tc == 0)) begin
        failures++;
        $display("FAIL blk_start dut%0d cnt=%0d got=%b",
                 d, mcnt[d], bs[d]);
      end
      if (er[d] !== merr[d]) begin
        failures++;
        $display("FAIL err dut%0d cnt=%0d got=%b want=%b",
                 d, mcnt[d], er[d], merr[d]);
      end
      if (en) begin
        if (tc == 0) new_block(d);
        mask = (WP[d] == 64) ? '1 : ((64'd1 << WP[d]) - 64'd1);
        sl = (blk[d] >> (tc * WP[d])) & mask;
        vld[d] = !drop;
        scr[d] = sl;
        syi[d] = bsync[d];
        if (tc == 0) begin
          for (int i = 0; i < 2; i++)
            sb[d].push_back(drop ? 1'b0 : bsync[d][i]);
        end
        for (int i = 0; i < WP[d]; i++)
          sb[d].push_back(drop ? 1'b0 : sl[i]);
        if (drop) merr[d] = 1'b1;
      end else begin
        vld[d] = ($urandom_range(0, 1) == 1);
        scr[d] = {$urandom, $urandom};
        syi[d] = 2'($urandom);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      logic [63:0] exp;
      bit b;
      exp = '0;
      checks++;
      if (sb[d].size() < WP[d]) begin
        failures++;
        $display("FAIL underflow dut%0d have=%0d need=%0d",
                 d, sb[d].size(), WP[d]);
      end else begin
        for (int i = 0; i < WP[d]; i++) begin
          b = sb[d].pop_front();
          if (MS[d]) exp[WP[d]-1-i] = b;
          else exp[i] = b;
        end
        if (pma[d] !== exp) begin
          failures++;
          $display("FAIL pma dut%0d cnt=%0d got=%h want=%h",
                   d, mcnt[d], pma[d], exp);
        end
      end
      mcnt[d] = (mcnt[d] == 32) ? 0 : mcnt[d] + 1;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    for (int d = 0; d < ND; d++) begin
      checks += 5;
      if (pma[d] !== 64'd0) begin
        failures++;
        $display("FAIL %s pma dut%0d got=%h want=0", tag, d, pma[d]);
      end
      if (ce[d] !== 1'b1) begin
        failures++;
        $display("FAIL %s clk_en dut%0d got=%b want=1", tag, d, ce[d]);
      end
      if (tcv[d] !== 2'd0) begin
        failures++;
        $display("FAIL %s trans dut%0d got=%0d want=0", tag, d, tcv[d]);
      end
      if (bs[d] !== 1'b1) begin
        failures++;
        $display("FAIL %s blk_start dut%0d got=%b want=1",
                 tag, d, bs[d]);
      end
      if (er[d] !== 1'b0) begin
        failures++;
        $display("FAIL %s err dut%0d got=%b want=0", tag, d, er[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = '1;
    for (int d = 0; d < ND; d++) begin
      syi[d] = 2'b00;
      scr[d] = '0;
      inc[d] = 64'h0123_4567_89AB_CDEF;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb_first();
    mode = 2;
    cycle(1'b0);
    checks += 2;
    if (pma[3] !== 64'h8000_0000) begin
      failures++;
      $display("FAIL msb_first got=%h want=80000000", pma[3]);
    end
    if (pma[0] !== 64'h1) begin
      failures++;
      $display("FAIL lsb_first got=%h want=1", pma[0]);
    end
    mode = 0;
  endtask

  task automatic test_stream();
    mode = 0;
    repeat (2063) cycle(1'b0);
  endtask

  task automatic test_err_drop();
    mode = 0;
    for (int n = 0; n < 40 && mcnt[0] != 5; n++) cycle(1'b0);
    cycle(1'b1);
    checks++;
    if (er[0] !== 1'b1) begin
      failures++;
      $display("FAIL err_rise got=%b want=1", er[0]);
    end
    repeat (100) cycle(1'b0);
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 40 && mcnt[0] != 17; n++) cycle(1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    mode = 0;
    repeat (200) cycle(1'b0);
  endtask

  task automatic test_back_to_back();
    mode = 1;
    repeat (700) cycle(1'b0);
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_stream();
    test_err_drop();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
